seq_muldivmod: RTL and testbench

- Iterative multi-cycle integer multiply / divide / modulo unit, parametrised in operand width.
- Signed and unsigned modes; divide-by-zero and signed-overflow results are fully defined.
- Valid/ready handshake on input and output.
- Serves as the shared arithmetic engine wherever constant-free mul/div/mod would otherwise infer large combinational arrays.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_core.sv | 94 +++++++++
 rtl/seq_muldivmod.sv | 141 ++++++++++++++
 tb/tb_seq_muldivmod.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide/modulo unit.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package muldiv_pkg;

  // Widest operand the magnitude helper handles.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_MOD  = 2'd2,
    OP_MULH = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of a zero-extended operand whose sign bit sits at index msb.
  // The caller keeps the low bits, so |-2^(msb)| comes back as 2^(msb).
  function automatic logic [MAXW-1:0] mag_fn(input logic [MAXW-1:0] x,
                                             input logic [5:0]      msb,
                                             input logic            sgn);
    logic [MAXW-1:0] r;
    r = x;
    if (sgn && x[msb]) begin
      r = -x;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring shift-subtract divide.
// Latency: WIDTH steps after start; done is high during the last step.
// Backpressure: none; steps every cycle while busy, start reloads unconditionally.
module muldiv_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] op_x,     // multiplicand / dividend (magnitude)
  input  logic [WIDTH-1:0] op_y,     // multiplier / divisor (magnitude)
  output logic             done,
  output logic [WIDTH-1:0] hi_dat,   // product high half / remainder
  output logic [WIDTH-1:0] lo_dat    // product low half / quotient
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // One iteration step: load on start, otherwise advance while busy.
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    b_d    = b_q;

    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q, sh_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // When div_ge holds the true difference is below b_q, so WIDTH bits suffice.
    div_diff  = div_shift[WIDTH-1:0] - b_q;

    if (start) begin
      busy_d = 1'b1;
      div_d  = div_mode;
      cnt_d  = CW'(WIDTH - 1);
      acc_d  = '0;
      sh_d   = div_mode ? op_x : op_y;
      b_d    = div_mode ? op_y : op_x;
    end else if (busy_q) begin
      if (div_q) begin
        // A zero divisor always subtracts: quotient all ones, remainder = dividend.
        acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = mul_sum[WIDTH:1];
        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
      end
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      b_q    <= b_d;
    end
  end

  assign done   = busy_q && (cnt_q == '0);
  assign hi_dat = acc_q;
  assign lo_dat = sh_q;

endmodule

// File: rtl/seq_muldivmod.sv
// Iterative signed/unsigned MUL, MULH, DIV, MOD with valid/ready on both sides.
// Latency: out_valid rises WIDTH+1 edges after the accept edge, operand independent.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module seq_muldivmod
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             div_by_zero
);

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic             neg_q;
  logic             a_neg_q;
  logic             bz_q;
  logic [WIDTH-1:0] res_q;
  logic             dbz_q;
  logic             out_valid_q;

  op_e              op_in;
  logic             in_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;

  logic             core_done;
  logic [WIDTH-1:0] core_hi, core_lo;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_d;
  logic               dbz_d;

  // Sign pre-processing on the incoming request.
  always_comb begin
    op_in  = op_e'(op);
    in_div = (op_in == OP_DIV) || (op_in == OP_MOD);
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_mag  = WIDTH'(mag_fn(MAXW'(a), 6'(WIDTH - 1), is_signed));
    b_mag  = WIDTH'(mag_fn(MAXW'(b), 6'(WIDTH - 1), is_signed));
    accept = in_valid && (state_q == IDLE);
  end

  assign in_ready = (state_q == IDLE);

  muldiv_core #(
    .WIDTH (WIDTH)
  ) muldiv_core_u (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept),
    .div_mode (in_div),
    .op_x     (in_div ? a_mag : a_mag),
    .op_y     (b_mag),
    .done     (core_done),
    .hi_dat   (core_hi),
    .lo_dat   (core_lo)
  );

  // Sign correction and result selection; divide-by-zero overrides the magnitudes.
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -core_lo : core_lo;
    rem_fix  = a_neg_q ? -core_hi : core_hi;
    dbz_d    = bz_q && ((op_q == OP_DIV) || (op_q == OP_MOD));
    res_d    = '0;
    case (op_q)
      OP_MUL:  res_d = prod_fix[WIDTH-1:0];
      OP_MULH: res_d = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  res_d = bz_q ? '1 : quo_fix;
      OP_MOD:  res_d = bz_q ? a_q : rem_fix;
      default: res_d = '0;
    endcase
  end

  // Control FSM with registered request fields and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      bz_q        <= 1'b0;
      res_q       <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= CALC;
            op_q    <= op_in;
            a_q     <= a;
            neg_q   <= a_neg ^ b_neg;
            a_neg_q <= a_neg;
            bz_q    <= (b == '0);
          end
        end
        CALC: begin
          if (core_done) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          res_q       <= res_d;
          dbz_q       <= dbz_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign res         = res_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_muldivmod.sv
// Self-checking bench for seq_muldivmod (WIDTH=8): directed corner cases plus random ops.
// Latency: checks out_valid at exactly WIDTH+1 edges after accept.
// Backpressure: exercises out_ready held low in DONE and async reset mid-operation.
module tb_seq_muldivmod;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         div_by_zero;

  int vectors;
  int miscompares;

  seq_muldivmod #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the interpreted operand values.
  function automatic logic [8:0] model(input logic [1:0] o, input logic s,
                                       input logic [7:0] x, input logic [7:0] y);
    longint      sx, sy, r;
    logic [63:0] rv;
    sx = s ? longint'($signed(x)) : longint'(x);
    sy = s ? longint'($signed(y)) : longint'(y);
    case (o)
      2'd0: begin r = sx * sy; rv = r; return {1'b0, rv[7:0]}; end
      2'd3: begin r = sx * sy; rv = r; return {1'b0, rv[15:8]}; end
      2'd1: begin
        if (sy == 0) return {1'b1, 8'hFF};
        r = sx / sy; rv = r; return {1'b0, rv[7:0]};
      end
      default: begin
        if (sy == 0) return {1'b1, x};
        r = sx % sy; rv = r; return {1'b0, rv[7:0]};
      end
    endcase
  endfunction

  // Present a request while IDLE; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] o, input logic s, input logic [7:0] x, input logic [7:0] y);
    op        = o;
    is_signed = s;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    a         = 8'($urandom);
    b         = 8'($urandom);
    op        = 2'($urandom);
    is_signed = 1'($urandom);
  endtask

  // Wait (bounded) for out_valid and check latency and result.
  task automatic collect(input string tag, input logic [8:0] e);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 30);
    check({tag, "_lat"}, 32'(n), 32'd9);
    check({tag, "_res"}, 32'(res), 32'(e[7:0]));
    check({tag, "_dbz"}, 32'(div_by_zero), 32'(e[8]));
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                        input logic [7:0] x, input logic [7:0] y);
    logic [8:0] e;
    e = model(o, s, x, y);
    issue(o, s, x, y);
    collect(tag, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] held;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    op          = 2'd0;
    is_signed   = 1'b0;
    a           = '0;
    b           = '0;

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, checked against fixed expectations and the model.
    run_op("u_div", 2'd1, 1'b0, 8'd200, 8'd7);
    check("u_div_const", 32'(res), 32'd28);
    run_op("u_mod", 2'd2, 1'b0, 8'd200, 8'd7);
    check("u_mod_const", 32'(res), 32'd4);
    run_op("s_div_a", 2'd1, 1'b1, 8'hF9, 8'h02);
    check("s_div_a_const", 32'(res), 32'hFD);
    run_op("s_mod_a", 2'd2, 1'b1, 8'hF9, 8'h02);
    check("s_mod_a_const", 32'(res), 32'hFF);
    run_op("s_div_b", 2'd1, 1'b1, 8'hF9, 8'hFE);
    check("s_div_b_const", 32'(res), 32'h03);
    run_op("s_mod_b", 2'd2, 1'b1, 8'hF9, 8'hFE);
    check("s_mod_b_const", 32'(res), 32'hFF);
    for (int s = 0; s < 2; s++) begin
      run_op("dz_div", 2'd1, 1'(s), 8'h5A, 8'h00);
      check("dz_div_const", 32'({div_by_zero, res}), 32'h1FF);
      run_op("dz_mod", 2'd2, 1'(s), 8'h5A, 8'h00);
      check("dz_mod_const", 32'({div_by_zero, res}), 32'h15A);
      run_op("dz_mul", 2'd0, 1'(s), 8'h5A, 8'h00);
      check("dz_mul_const", 32'({div_by_zero, res}), 32'h000);
    end
    run_op("dz_mod_neg", 2'd2, 1'b1, 8'hA5, 8'h00);
    run_op("dz_div_neg", 2'd1, 1'b1, 8'hA5, 8'h00);
    run_op("ovf_div", 2'd1, 1'b1, 8'h80, 8'hFF);
    check("ovf_div_const", 32'(res), 32'h80);
    run_op("ovf_mod", 2'd2, 1'b1, 8'h80, 8'hFF);
    check("ovf_mod_const", 32'(res), 32'h00);
    run_op("u_mul_ff", 2'd0, 1'b0, 8'hFF, 8'hFF);
    check("u_mul_ff_const", 32'(res), 32'h01);
    run_op("u_mulh_ff", 2'd3, 1'b0, 8'hFF, 8'hFF);
    check("u_mulh_ff_const", 32'(res), 32'hFE);
    run_op("s_mul_ff", 2'd0, 1'b1, 8'hFF, 8'hFF);
    run_op("s_mulh_ff", 2'd3, 1'b1, 8'hFF, 8'hFF);
    check("s_mulh_ff_const", 32'(res), 32'h00);
    run_op("s_mul_80", 2'd0, 1'b1, 8'h80, 8'h02);
    run_op("s_mulh_80", 2'd3, 1'b1, 8'h80, 8'h02);
    check("s_mulh_80_const", 32'(res), 32'hFF);

    // Backpressure: hold out_ready low in DONE with a competing request pending.
    issue(2'd0, 1'b0, 8'd13, 8'd11);
    out_ready = 1'b0;
    collect("hold", model(2'd0, 1'b0, 8'd13, 8'd11));
    held      = res;
    op        = 2'd1;
    is_signed = 1'b0;
    a         = 8'd91;
    b         = 8'd9;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_res", 32'(res), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_in_ready", 32'(in_ready), 32'd1);
    issue(2'd1, 1'b0, 8'd91, 8'd9);
    check("rel_busy", 32'(in_ready), 32'd0);
    collect("rel", model(2'd1, 1'b0, 8'd91, 8'd9));
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    issue(2'd2, 1'b0, 8'h5A, 8'h00);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", 32'(res), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("post_rst", 2'd1, 1'b0, 8'd100, 8'd10);
    check("post_rst_const", 32'(res), 32'd10);

    // Randomized operations against the model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] ro;
      logic       rs;
      logic [7:0] rx, ry;
      ro = 2'($urandom);
      rs = 1'($urandom);
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op("rand", ro, rs, rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
